// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: coin, selection, dispenser and change-hopper signals of the vending sequencer
interface vend_sequencer_if #(parameter int CREDIT_W = 8, parameter int ITEM_W = 2);
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic                sel_valid;
  logic [ITEM_W-1:0]   sel_item;
  logic [CREDIT_W-1:0] item_price;
  logic                in_stock;
  logic                cancel;
  logic                disp_done;
  logic                change_done;
  logic                disp_req;
  logic [ITEM_W-1:0]   disp_item;
  logic                change_req;
  logic [CREDIT_W-1:0] change_amt;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                out_of_stock;
  logic                insufficient;
  logic [2:0]          state;
  modport master (
    output coin_valid, coin_value, sel_valid, sel_item, item_price, in_stock, cancel, disp_done, change_done,
    input  disp_req, disp_item, change_req, change_amt, credit, coin_reject, out_of_stock, insufficient, state
  );
  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_item, item_price, in_stock, cancel, disp_done, change_done,
    output disp_req, disp_item, change_req, change_amt, credit, coin_reject, out_of_stock, insufficient, state
  );
endinterface

// File: rtl/vend_sequencer.sv
// vend_sequencer: credit accumulation, selection validation and dispense/change sequencing
module vend_sequencer #(
  parameter int CREDIT_W    = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int ITEM_W      = 2
) (
  input logic clk,
  input logic reset,
  vend_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, CREDIT = 3'd1, DISPENSE = 3'd2, CHANGE = 3'd3} state_t;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  state_t            st;
  logic [TW-1:0]     tcnt;
  logic [CREDIT_W:0] sum;
  logic              fits;
  logic              timeout;
  assign sum       = {1'b0, bus.credit} + {1'b0, bus.coin_value};
  assign fits      = !sum[CREDIT_W];
  assign timeout   = tcnt == TW'(TIMEOUT_CYC - 1);
  assign bus.state = st;
  // transaction FSM; every output is a register so pulses last exactly one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st               <= IDLE;
      tcnt             <= '0;
      bus.credit       <= '0;
      bus.disp_req     <= 1'b0;
      bus.disp_item    <= '0;
      bus.change_req   <= 1'b0;
      bus.change_amt   <= '0;
      bus.coin_reject  <= 1'b0;
      bus.out_of_stock <= 1'b0;
      bus.insufficient <= 1'b0;
    end else begin
      bus.coin_reject  <= 1'b0;
      bus.out_of_stock <= 1'b0;
      bus.insufficient <= 1'b0;
      case (st)
        IDLE: begin
          tcnt             <= '0;
          bus.insufficient <= bus.sel_valid && bus.credit == '0;
          if (bus.coin_valid) begin
            bus.credit <= bus.coin_value;
            st         <= CREDIT;
          end
        end
        CREDIT: begin
          bus.coin_reject <= bus.coin_valid && (bus.cancel || timeout || bus.sel_valid || !fits);
          tcnt            <= (bus.coin_valid || bus.sel_valid) ? '0 : tcnt + 1'b1;
          if (bus.cancel || timeout) begin
            bus.change_req <= 1'b1;
            bus.change_amt <= bus.credit;
            st             <= CHANGE;
          end else if (bus.sel_valid) begin
            if (!bus.in_stock) bus.out_of_stock <= 1'b1;
            else if (bus.credit < bus.item_price) bus.insufficient <= 1'b1;
            else begin
              bus.credit    <= bus.credit - bus.item_price;
              bus.disp_item <= bus.sel_item;
              bus.disp_req  <= 1'b1;
              st            <= DISPENSE;
            end
          end else if (bus.coin_valid && fits) bus.credit <= sum[CREDIT_W-1:0];
        end
        DISPENSE: begin
          bus.coin_reject <= bus.coin_valid;
          if (bus.disp_done) begin
            bus.disp_req <= 1'b0;
            if (bus.credit != '0) begin
              bus.change_req <= 1'b1;
              bus.change_amt <= bus.credit;
              st             <= CHANGE;
            end else st <= IDLE;
          end
        end
        CHANGE: begin
          bus.coin_reject <= bus.coin_valid;
          if (bus.change_done) begin
            bus.change_req <= 1'b0;
            bus.change_amt <= '0;
            bus.credit     <= '0;
            st             <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
